// File: rtl/action_input_if.sv
`default_nettype none
// ============================================================================
// Module      : action_input_if
// Description : Bundles the run enable, the raw per-player button vectors and
//               the per-turn action outputs of the action_input stage.
//               master : the button/switch source; it consumes the actions.
//               slave  : the action_input stage itself.
// Ports       : sw         run enable (1 = turn timer advances)
//               plr_1_btn  player 1 raw buttons [0]j [1]k [2]p [3]w [4]mf [5]mb
//               plr_2_btn  player 2 raw buttons, same bit mapping
//               plr_1_act  player 1 action code (valid with act_vld)
//               plr_2_act  player 2 action code (valid with act_vld)
//               act_vld    one-cycle strobe at each turn boundary
// Revision    : 1.0 - initial release
// ============================================================================
interface action_input_if;
  logic       sw;
  logic [5:0] plr_1_btn;
  logic [5:0] plr_2_btn;
  logic [2:0] plr_1_act;
  logic [2:0] plr_2_act;
  logic       act_vld;

  modport master (
    output sw, plr_1_btn, plr_2_btn,
    input  plr_1_act, plr_2_act, act_vld
  );

  modport slave (
    input  sw, plr_1_btn, plr_2_btn,
    output plr_1_act, plr_2_act, act_vld
  );
endinterface
`default_nettype wire

// File: rtl/action_input.sv
`default_nettype none
// ============================================================================
// Module      : action_input
// Description : Upstream input stage for Board. Synchronises and debounces
//               both players' raw button vectors, latches the first press of
//               each player per turn and presents both action codes for one
//               cycle at every turn boundary, qualified by act_vld. Between
//               boundaries both codes read none (000).
// Ports       : clk  single clock, rising edge
//               rst  synchronous reset, active low
//               bus  action_input_if.slave (sw, plr_x_btn in; plr_x_act,
//                    act_vld out)
// Params      : DEBOUNCE_CYCLES (>=2) stable cycles before a level changes
//               TURN_CYCLES     (>=2) clock cycles per turn
// Codes       : none=000 j=001 k=010 p=011 w=100 mf=101 mb=110
// Revision    : 1.0 - initial release
// ============================================================================
module action_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TURN_CYCLES     = 8
) (
  input  logic           clk,
  input  logic           rst,
  action_input_if.slave  bus
);

  localparam int NUM_PLR = 2;
  localparam int NUM_BTN = 6;
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int TURN_W  = $clog2(TURN_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } sel_state_t;

  // Lowest set bit wins: bit i maps to code i+1 (j > k > p > w > mf > mb).
  function automatic logic [2:0] prio_code(input logic [NUM_BTN-1:0] v);
    logic [2:0] code;
    code = 3'b000;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) code = 3'(i + 1);
    end
    return code;
  endfunction

  logic [NUM_BTN-1:0] w_btn    [NUM_PLR];
  logic [NUM_BTN-1:0] r_sync   [NUM_PLR];
  logic [NUM_BTN-1:0] r_deb    [NUM_PLR];
  logic [CNT_W-1:0]   r_cnt    [NUM_PLR][NUM_BTN];
  logic [NUM_BTN-1:0] w_press  [NUM_PLR];

  sel_state_t         r_state  [NUM_PLR];
  sel_state_t         w_state_nxt [NUM_PLR];
  logic [2:0]         r_code   [NUM_PLR];
  logic [2:0]         w_code_nxt  [NUM_PLR];

  logic [TURN_W-1:0]  r_turn;
  logic               w_boundary;
  logic [2:0]         r_act    [NUM_PLR];
  logic               r_vld;

  assign w_btn[0] = bus.plr_1_btn;
  assign w_btn[1] = bus.plr_2_btn;

  // --------------------------------------------------------------------------
  // Sync + debounce. The counter only runs while sync and deb disagree, so a
  // single agreeing cycle restarts the stability window.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PLR; p++) begin
        r_sync[p] <= '0;
        r_deb[p]  <= '0;
        for (int b = 0; b < NUM_BTN; b++) begin
          r_cnt[p][b] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NUM_PLR; p++) begin
        r_sync[p] <= w_btn[p];
        for (int b = 0; b < NUM_BTN; b++) begin
          if (r_sync[p][b] == r_deb[p][b]) begin
            r_cnt[p][b] <= '0;
          end else if (r_cnt[p][b] == DEB_LAST) begin
            r_deb[p][b] <= r_sync[p][b];
            r_cnt[p][b] <= '0;
          end else begin
            r_cnt[p][b] <= r_cnt[p][b] + 1'b1;
          end
        end
      end
    end
  end

  // A press is the edge on which deb is about to flip 0->1.
  always_comb begin
    for (int p = 0; p < NUM_PLR; p++) begin
      w_press[p] = '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        w_press[p][b] = r_sync[p][b] & ~r_deb[p][b] & (r_cnt[p][b] == DEB_LAST);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Turn timer. Holds while sw is low, which also suppresses the boundary.
  // --------------------------------------------------------------------------
  assign w_boundary = bus.sw && (r_turn == TURN_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_turn <= '0;
    end else if (bus.sw) begin
      r_turn <= (r_turn == TURN_LAST) ? '0 : r_turn + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-player selection FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PLR; p++) begin
        r_state[p] <= IDLE;
        r_code[p]  <= 3'b000;
      end
    end else begin
      for (int p = 0; p < NUM_PLR; p++) begin
        r_state[p] <= w_state_nxt[p];
        r_code[p]  <= w_code_nxt[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLR; p++) begin
      w_state_nxt[p] = r_state[p];
      w_code_nxt[p]  = r_code[p];
      if (w_boundary) begin
        // The ending turn consumes the current selection; a press landing on
        // the boundary edge itself arms the selection for the next turn.
        if (|w_press[p]) begin
          w_state_nxt[p] = ARMED;
          w_code_nxt[p]  = prio_code(w_press[p]);
        end else begin
          w_state_nxt[p] = IDLE;
          w_code_nxt[p]  = 3'b000;
        end
      end else if (r_state[p] == IDLE && |w_press[p]) begin
        w_state_nxt[p] = ARMED;
        w_code_nxt[p]  = prio_code(w_press[p]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs: codes are non-zero only in the cycle after a boundary.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= 1'b0;
      for (int p = 0; p < NUM_PLR; p++) begin
        r_act[p] <= 3'b000;
      end
    end else begin
      r_vld <= w_boundary;
      for (int p = 0; p < NUM_PLR; p++) begin
        r_act[p] <= (w_boundary && r_state[p] == ARMED) ? r_code[p] : 3'b000;
      end
    end
  end

  assign bus.plr_1_act = r_act[0];
  assign bus.plr_2_act = r_act[1];
  assign bus.act_vld   = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_action_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_action_input
// Description : Self-checking bench for action_input. Directed scenarios, each
//               starting from a fresh reset, push the expected boundary pulses
//               (edge number, P1 code, P2 code) into a scoreboard; a monitor on
//               the falling edge pops and compares every act_vld pulse and
//               checks that the outputs idle at 000/0 otherwise. Edge numbers
//               count rising edges after the last reset edge (edge 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_action_input;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  action_input_if bus ();

  action_input #(
    .DEBOUNCE_CYCLES (4),
    .TURN_CYCLES     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         edge_no;
    logic [2:0] a1;
    logic [2:0] a2;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ecnt     = 0;

  always @(posedge clk) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  // Monitor: compares every pulse against the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (bus.act_vld === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_vld edge=%0d p1=%b p2=%b (no pulse expected)",
                   ecnt, bus.plr_1_act, bus.plr_2_act);
        end else begin
          e = sb.pop_front();
          if (ecnt != e.edge_no || bus.plr_1_act !== e.a1 || bus.plr_2_act !== e.a2) begin
            failures++;
            $display("FAIL pulse got edge=%0d p1=%b p2=%b expected edge=%0d p1=%b p2=%b",
                     ecnt, bus.plr_1_act, bus.plr_2_act, e.edge_no, e.a1, e.a2);
          end
        end
      end else begin
        checks++;
        if (bus.act_vld !== 1'b0 || bus.plr_1_act !== 3'b000 || bus.plr_2_act !== 3'b000) begin
          failures++;
          $display("FAIL idle_out edge=%0d got vld=%b p1=%b p2=%b expected 0/000/000",
                   ecnt, bus.act_vld, bus.plr_1_act, bus.plr_2_act);
        end
      end
    end
  end

  task automatic step_to(input int n);
    int g;
    g = 0;
    while (ecnt != n && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (ecnt != n) begin
      checks++;
      failures++;
      $display("FAIL step_to timeout edge=%0d expected %0d", ecnt, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.act_vld !== 1'b0 || bus.plr_1_act !== 3'b000 || bus.plr_2_act !== 3'b000) begin
        failures++;
        $display("FAIL reset_out got vld=%b p1=%b p2=%b expected 0/000/000",
                 bus.act_vld, bus.plr_1_act, bus.plr_2_act);
      end
    end
    rst = 1'b1;
  endtask

  task automatic expect_pulse(input int e, input logic [2:0] a1, input logic [2:0] a2);
    sb.push_back('{e, a1, a2});
  endtask

  task automatic finish_scn(input string name, input int last);
    step_to(last);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s missing_pulses got %0d left expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    bus.sw        = 1'b1;
    bus.plr_1_btn = 6'b000000;
    bus.plr_2_btn = 6'b000000;

    // Reset with all buttons active; first boundary pulse at edge 8, empty.
    bus.plr_1_btn = 6'b111111;
    bus.plr_2_btn = 6'b111111;
    do_reset();
    bus.plr_1_btn = 6'b000000;
    bus.plr_2_btn = 6'b000000;
    expect_pulse(8, 3'b000, 3'b000);
    finish_scn("reset", 8);

    // Single press held: one action only.
    do_reset();
    bus.plr_1_btn = 6'b000010;
    expect_pulse(8,  3'b010, 3'b000);
    expect_pulse(16, 3'b000, 3'b000);
    expect_pulse(24, 3'b000, 3'b000);
    finish_scn("single_press", 24);
    bus.plr_1_btn = 6'b000000;

    // Bounce rejection, then a stable mf press.
    do_reset();
    expect_pulse(8,  3'b000, 3'b000);
    expect_pulse(16, 3'b101, 3'b000);
    expect_pulse(24, 3'b000, 3'b000);
    bus.plr_1_btn = 6'b010000;
    step_to(1);  bus.plr_1_btn = 6'b000000;
    step_to(2);  bus.plr_1_btn = 6'b010000;
    step_to(3);  bus.plr_1_btn = 6'b000000;
    step_to(8);  bus.plr_1_btn = 6'b010000;
    step_to(20); bus.plr_1_btn = 6'b000000;
    finish_scn("bounce", 24);

    // Priority (P2 j+mb) and first-wins (P1 p then w).
    do_reset();
    expect_pulse(8,  3'b011, 3'b001);
    expect_pulse(16, 3'b000, 3'b000);
    bus.plr_1_btn = 6'b000100;
    bus.plr_2_btn = 6'b100001;
    step_to(2); bus.plr_1_btn = 6'b001100;
    step_to(8); bus.plr_1_btn = 6'b000000; bus.plr_2_btn = 6'b000000;
    finish_scn("priority", 16);

    // Press event landing exactly on boundary edge 8 goes to the next turn.
    do_reset();
    expect_pulse(8,  3'b000, 3'b000);
    expect_pulse(16, 3'b010, 3'b000);
    step_to(3); bus.plr_1_btn = 6'b000010;
    step_to(8); bus.plr_1_btn = 6'b000000;
    finish_scn("collision", 16);

    // sw low for 5 edges delays the boundary from 8 to 13.
    do_reset();
    expect_pulse(13, 3'b001, 3'b000);
    expect_pulse(21, 3'b000, 3'b000);
    bus.plr_1_btn = 6'b000001;
    step_to(3);  bus.sw = 1'b0;
    step_to(8);  bus.sw = 1'b1;
    step_to(13); bus.plr_1_btn = 6'b000000;
    finish_scn("enable", 21);

    // Reset at counter 5 with P1 armed discards the selection.
    do_reset();
    bus.plr_1_btn = 6'b001000;
    step_to(5);
    bus.plr_1_btn = 6'b000000;
    do_reset();
    expect_pulse(8, 3'b000, 3'b000);
    finish_scn("mid_reset", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/action_input.md
# action_input

Upstream input stage for `Board`. It takes raw, bouncy per-player button vectors and debounces them. It latches at most one action per player per turn and presents both players' 3-bit action codes to `Board` for exactly one cycle at each turn boundary, with a valid strobe. Between boundaries both action outputs read `none`, so `Board` never consumes an action twice.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles (after the sync stage) required before a debounced level changes; must be at least 2.
- `TURN_CYCLES`, 8: clock cycles per turn; must be at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `sw` in 1: run enable; 1 means the turn timer advances.
- `plr_1_btn` in 6: raw buttons, one bit per action: [0] j, [1] k, [2] p, [3] w, [4] mf, [5] mb.
- `plr_2_btn` in 6: same mapping as `plr_1_btn`, for player 2.
- `plr_1_act` out 3: player 1 action code to `Board`.
- `plr_2_act` out 3: player 2 action code to `Board`.
- `act_vld` out 1: one-cycle strobe marking the cycle in which `plr_*_act` carry the turn's actions.

Action codes: none=000, j=001, k=010, p=011, w=100, mf=101, mb=110. Bit i maps to code i+1; code 111 is never produced.

## Operation
- Reset (`rst`=0 at an edge) clears the following:
  - sync registers, debounced levels and debounce counters to 0;
  - both selections to IDLE/none;
  - turn counter to 0;
  - `plr_1_act`, `plr_2_act` to 000 and `act_vld` to 0.
- Reset has priority over every other event, including a boundary in the same cycle.
- Sync: each raw bit is registered once (`sync`) before debouncing.
- Debounce, per bit:
  - If `sync` equals `deb`, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES`-1 and a mismatch is still present, `deb` flips and the counter clears at that edge.
  - A press event is the edge on which `deb` flips 0→1. Releases produce no event.
- Selection FSM, per player, with states IDLE and ARMED(code):
  - IDLE + one or more press events: go to ARMED with the lowest-index pressed bit's code. Priority is j>k>p>w>mf>mb.
  - ARMED + any press: ignored; the first press wins for the turn.
  - At a boundary, the selection is consumed and the FSM returns to IDLE. If a press event occurs in the boundary cycle itself, the FSM goes directly to ARMED for the next turn; that press is not lost and not applied to the turn now ending.
- Turn counter:
  - While `sw`=1, it counts 0..`TURN_CYCLES`-1 and wraps.
  - The boundary is the edge at which the counter is `TURN_CYCLES`-1 and `sw`=1.
  - While `sw`=0, the counter holds, no boundary occurs and `act_vld` stays 0. Selections still capture presses.
- Outputs, registered:
  - At the boundary edge, `plr_x_act` takes the player's pre-edge selection code (000 if IDLE) and `act_vld` takes 1.
  - At every other edge, `plr_x_act` takes 000 and `act_vld` takes 0.
- A button held across boundaries produces a single press event, so it yields one action only. Release and re-press are needed to act again.

## Timing
- Sync: a raw level change present before edge E is captured in `sync` at E.
- Debounce: `deb` flips, and the selection latches, at edge E+`DEBOUNCE_CYCLES`, provided the level is stable throughout.
- Boundary timing from reset release (counter 0 after the last reset edge, `sw`=1):
  - The first boundary is at edge `TURN_CYCLES`.
  - Subsequent boundaries follow every `TURN_CYCLES` edges.
  - Outputs are valid in the cycle following each boundary edge, for exactly one cycle.
- Latency: a press latched at edge L appears at the first boundary edge at or after L+1, i.e. in the next turn if L is itself a boundary edge.
- Reset mid-turn discards latched selections and restarts the counter at 0.

## Test plan
- Reset: hold `rst`=0 for 2 edges with buttons active → `plr_1_act`=`plr_2_act`=000, `act_vld`=0. After release, the first `act_vld` pulse occurs at edge 8 (defaults) with both codes 000.
- Single press: P1 k (bit1) held from edge 1 → latched by edge 5. At edge 8, `plr_1_act`=010, `plr_2_act`=000, `act_vld`=1. At edge 9 everything returns to 000/0. No action at edge 16 while the button is still held.
- Bounce rejection: P1 mf toggles 1,0,1,0 on successive cycles and then stays 0 → no press event; 000 at the boundary. The same pulse held 4 stable cycles → 101.
- Priority and first-wins:
  - P2 j and mb rise together → 001.
  - P1 p latched, then w pressed 2 cycles later in the same turn → 011.
- Boundary collision: a P1 press event lands exactly on boundary edge 8 → edge 8 outputs 000 for P1; the edge 16 output is P1's code.
- Enable and reset:
  - `sw`=0 for 5 cycles mid-turn delays the next `act_vld` by exactly 5 cycles, with the latched code preserved.
  - `rst`=0 with P1 ARMED at counter 5 → the next boundary after release outputs 000 and occurs 8 edges after release.
